load_store_unit: RTL



---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Core-side and memory-side signal bundle for the load/store unit.
interface load_store_unit_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, core_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, core_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: aligns core accesses onto a 32-bit memory bus and
// extends load data back to the core; flags misaligned/reserved accesses.
module load_store_unit (
    input  logic              clk_i,
    input  logic              rst_i,
    load_store_unit_if.slave  bus
);
    localparam int unsigned DW = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] word_q;
    logic [1:0]    off_q;
    logic [2:0]    size_q;
    logic          err_q;

    logic          legal;
    logic          mem_req;
    logic          capture;
    logic          fault;
    logic [3:0]    be;

    // Alignment / size legality of the current core request
    always_comb begin
        legal = 1'b0;
        case (bus.core_size_i)
            3'd0, 3'd4: legal = 1'b1;
            3'd1, 3'd5: legal = ~bus.core_addr_i[0];
            3'd2:       legal = (bus.core_addr_i[1:0] == 2'b00);
            default:    legal = 1'b0;
        endcase
    end

    // Next-state and handshake decode
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        capture = 1'b0;
        fault   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.core_req_i) begin
                    if (legal) begin
                        mem_req = 1'b1;
                        capture = bus.mem_ready_i;
                        state_d = bus.mem_ready_i ? DONE : WAIT;
                    end else begin
                        fault   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                capture = bus.mem_ready_i;
                if (bus.mem_ready_i) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= fault;
            if (fault) begin
                word_q <= '0;
                off_q  <= '0;
                size_q <= '0;
            end else if (capture) begin
                word_q <= bus.mem_rd_i;
                off_q  <= bus.core_addr_i[1:0];
                size_q <= bus.core_size_i;
            end
        end
    end

    // Byte-lane enables for the store width
    always_comb begin
        be = 4'b1111;
        case (bus.core_size_i[1:0])
            2'd0:    be = 4'b0001 << bus.core_addr_i[1:0];
            2'd1:    be = 4'b0011 << {bus.core_addr_i[1], 1'b0};
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        bus.mem_wd_o = bus.core_wd_i;
        case (bus.core_size_i[1:0])
            2'd0:    bus.mem_wd_o = {4{bus.core_wd_i[7:0]}};
            2'd1:    bus.mem_wd_o = {2{bus.core_wd_i[15:0]}};
            default: bus.mem_wd_o = bus.core_wd_i;
        endcase
    end

    // Lane select and extension of the captured read word
    always_comb begin
        bus.core_rd_o = word_q;
        case (size_q)
            3'd0: bus.core_rd_o = DW'($signed(word_q[8*off_q +: 8]));
            3'd4: bus.core_rd_o = DW'(word_q[8*off_q +: 8]);
            3'd1: bus.core_rd_o = DW'($signed(word_q[16*off_q[1] +: 16]));
            3'd5: bus.core_rd_o = DW'(word_q[16*off_q[1] +: 16]);
            default: bus.core_rd_o = word_q;
        endcase
    end

    // Request and stall are held low while reset is asserted
    assign bus.mem_req_o    = mem_req & ~rst_i;
    assign bus.mem_we_o     = bus.core_we_i & bus.mem_req_o;
    assign bus.mem_be_o     = bus.mem_we_o ? be : 4'b0000;
    assign bus.mem_addr_o   = bus.core_addr_i;
    assign bus.core_stall_o = bus.core_req_i & (state_q != DONE) & ~rst_i;
    assign bus.core_err_o   = err_q & (state_q == DONE);

endmodule
